refresh_responder_8: RTL and testbench

Multiplexer-side responder for the refresh command stream in the LPDDR4 memory controller. It arbitrates the refresh request against the 8 bank machines, drains and blocks them, and grants the stream. It forwards the precharge-all and refresh commands to the DFI command slot with one registered cycle, and checks protocol and tRP/tRFC spacing on the fly. Sticky error flags and a refresh counter feed the CSR block.

---
 rtl/lpddr4_cmd_pkg.sv | 45 ++++
 rtl/refresh_responder_8_if.sv | 15 +
 rtl/ref_spacing_checker.sv | 32 +++
 rtl/refresh_responder_8.sv | 125 ++++++++++++
 tb/tb_refresh_responder_8.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpddr4_cmd_pkg.sv
// Shared LPDDR4 command definitions: strobe decode patterns, refresh-responder
// FSM states and the DFI command word with its idle value.
package lpddr4_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GRANT
  } ref_state_t;

  typedef struct packed {
    logic ras;
    logic cas;
    logic we;
  } strobe_t;

  localparam strobe_t STROBE_PREA = '{ras: 1'b1, cas: 1'b0, we: 1'b1};
  localparam strobe_t STROBE_REF  = '{ras: 1'b1, cas: 1'b1, we: 1'b0};
  localparam int      PREA_ALL_BIT = 10;

  typedef struct packed {
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [16:0] address;
    logic [2:0]  bank;
  } dfi_cmd_t;

  localparam dfi_cmd_t DFI_IDLE = '{
    cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, address: '0, bank: '0
  };

  function automatic dfi_cmd_t to_dfi(strobe_t s, logic [16:0] a, logic [2:0] ba);
    dfi_cmd_t c;
    c.cs_n    = 1'b0;
    c.ras_n   = ~s.ras;
    c.cas_n   = ~s.cas;
    c.we_n    = ~s.we;
    c.address = a;
    c.bank    = ba;
    return c;
  endfunction

endpackage

// File: rtl/refresh_responder_8_if.sv
// Refresher-to-multiplexer command slot: the refresher is the master and the
// responder grants the slot through ready.
interface refresh_responder_8_if;
  logic        valid;
  logic        ready;
  logic        last;
  logic [16:0] a;
  logic [2:0]  ba;
  logic        cas;
  logic        ras;
  logic        we;

  modport master (output valid, last, a, ba, cas, ras, we, input ready);
  modport slave  (input valid, last, a, ba, cas, ras, we, output ready);
endinterface

// File: rtl/ref_spacing_checker.sv
// Tracks the tRP/tRFC window after each forwarded PREA/REF and flags any
// command that lands inside it; the window keeps running between grants.
module ref_spacing_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prea_fire,
  input  logic       ref_fire,
  input  logic [7:0] trp_cfg,
  input  logic [7:0] trfc_cfg,
  input  logic       err_clr,
  output logic       err_timing
);

  logic [7:0] window;
  logic       violation;

  assign violation = (prea_fire | ref_fire) && (window != 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window     <= 8'd0;
      err_timing <= 1'b0;
    end else begin
      if (prea_fire)           window <= trp_cfg - 8'd1;
      else if (ref_fire)       window <= trfc_cfg - 8'd1;
      else if (window != 8'd0) window <= window - 8'd1;
      // A fresh violation outranks a simultaneous clear.
      err_timing <= violation | (err_timing & ~err_clr);
    end
  end

endmodule

// File: rtl/refresh_responder_8.sv
// Multiplexer-side refresh responder: drains the bank machines, grants the
// refresher, forwards PREA/REF to DFI one cycle later and checks the stream.
module refresh_responder_8
  import lpddr4_cmd_pkg::*;
#(
  parameter int NBANKS = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  refresh_responder_8_if.slave  ref_cmd,
  input  logic [NBANKS-1:0]     bm_idle,
  output logic                  bm_block,
  input  logic [7:0]            ref_tRP_cfg,
  input  logic [7:0]            ref_tRFC_cfg,
  input  logic [3:0]            ref_POSTPONE_cfg,
  output logic                  dfi_cs_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic [16:0]           dfi_address,
  output logic [2:0]            dfi_bank,
  input  logic                  err_clr,
  output logic                  err_proto,
  output logic                  err_timing,
  output logic                  err_count,
  output logic [15:0]           ref_issued
);

  ref_state_t state;
  logic       ready_q;
  dfi_cmd_t   dfi_q;
  logic [3:0] grant_refs;

  strobe_t    strobe;
  logic       in_grant;
  logic       is_prea;
  logic       is_ref;
  logic       prea_fire;
  logic       ref_fire;
  logic       proto_hit;
  logic       grant_end;
  logic [3:0] count_next;
  logic       count_hit;

  assign strobe    = '{ras: ref_cmd.ras, cas: ref_cmd.cas, we: ref_cmd.we};
  assign in_grant  = (state == ST_GRANT);
  assign is_prea   = (strobe == STROBE_PREA) && ref_cmd.a[PREA_ALL_BIT];
  assign is_ref    = (strobe == STROBE_REF);
  assign prea_fire = in_grant & is_prea;
  assign ref_fire  = in_grant & is_ref;
  assign proto_hit = in_grant & (|strobe) & ~(is_prea | is_ref);
  assign grant_end = in_grant & ref_cmd.last;

  // Per-grant REF count saturates so a runaway refresher cannot alias back to a match.
  assign count_next = (ref_fire && grant_refs != 4'hF) ? grant_refs + 4'd1 : grant_refs;
  assign count_hit  = grant_end && (count_next != ref_POSTPONE_cfg);

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      bm_block   <= 1'b0;
      dfi_q      <= DFI_IDLE;
      err_proto  <= 1'b0;
      err_count  <= 1'b0;
      ref_issued <= 16'd0;
      grant_refs <= 4'd0;
    end else begin
      dfi_q      <= (prea_fire | ref_fire) ? to_dfi(strobe, ref_cmd.a, ref_cmd.ba) : DFI_IDLE;
      err_proto  <= proto_hit | (err_proto & ~err_clr);
      err_count  <= count_hit | (err_count & ~err_clr);
      grant_refs <= grant_end ? 4'd0 : count_next;
      if (ref_fire) ref_issued <= ref_issued + 16'd1;

      case (state)
        ST_IDLE: begin
          if (ref_cmd.valid) begin
            state    <= ST_DRAIN;
            bm_block <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (&bm_idle) begin
            state   <= ST_GRANT;
            ready_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (ref_cmd.last) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            bm_block <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ready_q  <= 1'b0;
          bm_block <= 1'b0;
        end
      endcase
    end
  end

  assign ref_cmd.ready = ready_q;
  assign dfi_cs_n      = dfi_q.cs_n;
  assign dfi_ras_n     = dfi_q.ras_n;
  assign dfi_cas_n     = dfi_q.cas_n;
  assign dfi_we_n      = dfi_q.we_n;
  assign dfi_address   = dfi_q.address;
  assign dfi_bank      = dfi_q.bank;

  ref_spacing_checker u_spacing (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .prea_fire  (prea_fire),
    .ref_fire   (ref_fire),
    .trp_cfg    (ref_tRP_cfg),
    .trfc_cfg   (ref_tRFC_cfg),
    .err_clr    (err_clr),
    .err_timing (err_timing)
  );

endmodule

// File: tb/tb_refresh_responder_8.sv
// Directed bench for refresh_responder_8: an event-level reference model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_refresh_responder_8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  bm_idle;
  logic        bm_block;
  logic [7:0]  trp_cfg, trfc_cfg;
  logic [3:0]  postpone_cfg;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [16:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic        err_clr, err_proto, err_timing, err_count;
  logic [15:0] ref_issued;

  refresh_responder_8_if bus ();

  refresh_responder_8 #(.NBANKS(8)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .ref_cmd          (bus),
    .bm_idle          (bm_idle),
    .bm_block         (bm_block),
    .ref_tRP_cfg      (trp_cfg),
    .ref_tRFC_cfg     (trfc_cfg),
    .ref_POSTPONE_cfg (postpone_cfg),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_address      (dfi_address),
    .dfi_bank         (dfi_bank),
    .err_clr          (err_clr),
    .err_proto        (err_proto),
    .err_timing       (err_timing),
    .err_count        (err_count),
    .ref_issued       (ref_issued)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  int  cyc = 0;
  bit  model_on = 0;
  bit  m_grant, m_drain;
  bit  m_err_p, m_err_t, m_err_c;
  int  m_issued, m_refs;
  bit  m_have_last;
  int  m_last_cyc, m_gap;
  bit  m_cs_n, m_ras_n, m_cas_n, m_we_n;
  int  m_addr, m_bank;
  bit  e_prea, e_ref, e_strobe, new_p, new_t, new_c;

  always @(posedge sys_clk) begin
    cyc++;
    model_on = 1;
    if (!sys_rst_n) begin
      m_grant = 0; m_drain = 0;
      m_err_p = 0; m_err_t = 0; m_err_c = 0;
      m_issued = 0; m_refs = 0; m_have_last = 0;
      m_cs_n = 1; m_ras_n = 1; m_cas_n = 1; m_we_n = 1; m_addr = 0; m_bank = 0;
    end else begin
      e_strobe = bus.ras | bus.cas | bus.we;
      e_prea   = m_grant && bus.ras && bus.we && !bus.cas && bus.a[10];
      e_ref    = m_grant && bus.ras && bus.cas && !bus.we;
      new_p    = m_grant && e_strobe && !e_prea && !e_ref;
      new_t    = 0;
      new_c    = 0;
      if (e_prea || e_ref) begin
        // Too close if fewer than the required cycles separate the two commands.
        if (m_have_last && (cyc - m_last_cyc) < m_gap) new_t = 1;
        m_have_last = 1;
        m_last_cyc  = cyc;
        m_gap       = e_prea ? int'(trp_cfg) : int'(trfc_cfg);
        m_cs_n = 0; m_ras_n = !bus.ras; m_cas_n = !bus.cas; m_we_n = !bus.we;
        m_addr = int'(bus.a); m_bank = int'(bus.ba);
      end else begin
        m_cs_n = 1; m_ras_n = 1; m_cas_n = 1; m_we_n = 1; m_addr = 0; m_bank = 0;
      end
      if (e_ref) begin
        m_refs++;
        m_issued = (m_issued + 1) % 65536;
      end
      if (m_grant && bus.last) begin
        new_c  = ((m_refs > 15) ? 15 : m_refs) != int'(postpone_cfg);
        m_refs = 0;
      end
      m_err_p = new_p || (m_err_p && !err_clr);
      m_err_t = new_t || (m_err_t && !err_clr);
      m_err_c = new_c || (m_err_c && !err_clr);
      if (m_grant) begin
        if (bus.last) m_grant = 0;
      end else if (m_drain) begin
        if (bm_idle == 8'hFF) begin m_drain = 0; m_grant = 1; end
      end else if (bus.valid) begin
        m_drain = 1;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (model_on) begin
      check("ready",      bus.ready,   m_grant);
      check("bm_block",   bm_block,    m_grant | m_drain);
      check("dfi_cs_n",   dfi_cs_n,    m_cs_n);
      check("dfi_ras_n",  dfi_ras_n,   m_ras_n);
      check("dfi_cas_n",  dfi_cas_n,   m_cas_n);
      check("dfi_we_n",   dfi_we_n,    m_we_n);
      check("dfi_addr",   dfi_address, m_addr);
      check("dfi_bank",   dfi_bank,    m_bank);
      check("err_proto",  err_proto,   m_err_p);
      check("err_timing", err_timing,  m_err_t);
      check("err_count",  err_count,   m_err_c);
      check("ref_issued", ref_issued,  m_issued);
    end
  end

  // Cycle stamps of the last PREA and REF seen on the DFI side.
  int dfi_prea_cyc = -1;
  int dfi_ref_cyc  = -1;
  always @(negedge sys_clk) begin
    if (dfi_cs_n == 1'b0) begin
      if (!dfi_ras_n && dfi_cas_n && !dfi_we_n) dfi_prea_cyc = cyc;
      if (!dfi_ras_n && !dfi_cas_n && dfi_we_n) dfi_ref_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_cmd(input bit ras, input bit cas, input bit we, input logic [16:0] a);
    bus.ras = ras; bus.cas = cas; bus.we = we; bus.a = a; bus.ba = 3'd0;
  endtask

  task automatic clear_cmd();
    set_cmd(0, 0, 0, 17'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    bus.valid = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if (bus.ready === 1'b1) break;
    end
    check("grant_timeout", bus.ready, 1);
  endtask

  task automatic run_grant(input bit with_prea, input int n_ref, output int lat);
    wait_grant(lat);
    if (with_prea) begin
      set_cmd(1, 0, 1, 17'h00400);
      tick(); clear_cmd();
      repeat (int'(trp_cfg) - 1) tick();
    end
    for (int i = 0; i < n_ref; i++) begin
      set_cmd(1, 1, 0, 17'd0);
      tick(); clear_cmd();
      repeat (int'(trfc_cfg) - 1) tick();
    end
    bus.valid = 0; bus.last = 1;
    tick();
    bus.last = 0;
  endtask

  int lat;
  int base;

  initial begin
    sys_rst_n = 0;
    bus.valid = 0; bus.last = 0; clear_cmd();
    bm_idle = 8'hFF; err_clr = 0;
    trp_cfg = 8'd3; trfc_cfg = 8'd10; postpone_cfg = 4'd1;
    repeat (3) tick();
    check("rst_ready",  bus.ready,  0);
    check("rst_block",  bm_block,   0);
    check("rst_cs_n",   dfi_cs_n,   1);
    check("rst_issued", ref_issued, 0);
    sys_rst_n = 1;
    tick();

    // Single PREA + REF sequence.
    run_grant(1, 1, lat);
    check("grant_latency", lat, 2);
    check("prea_ref_gap", dfi_ref_cyc - dfi_prea_cyc, 3);
    check("issued_1", ref_issued, 1);
    check("no_err", {err_proto, err_timing, err_count}, 0);
    check("ready_drop", bus.ready, 0);
    repeat (3) tick();

    // Postponed refreshes: full count, then one short.
    postpone_cfg = 4'd4;
    base = int'(ref_issued);
    run_grant(1, 4, lat);
    check("issued_4", int'(ref_issued) - base, 4);
    check("count_ok", err_count, 0);
    repeat (2) tick();
    run_grant(1, 3, lat);
    check("count_bad", err_count, 1);
    pulse_clr();
    check("count_clr", err_count, 0);
    repeat (2) tick();

    // Slow drain, then timing and protocol faults inside one grant.
    bm_idle = 8'hFE;
    bus.valid = 1;
    tick();
    for (int i = 0; i < 20; i++) begin
      check("drain_ready", bus.ready, 0);
      check("drain_block", bm_block, 1);
      tick();
    end
    bm_idle = 8'hFF;
    tick();
    check("grant_after_idle", bus.ready, 1);
    set_cmd(1, 0, 1, 17'h00400);
    tick(); clear_cmd();
    tick();
    set_cmd(1, 1, 0, 17'd0);
    tick(); clear_cmd();
    check("trp_violation", err_timing, 1);
    check("ref_forwarded", {dfi_cs_n, dfi_cas_n}, 2'b00);
    pulse_clr();
    check("timing_clr", err_timing, 0);
    set_cmd(1, 1, 0, 17'd0); err_clr = 1;
    tick(); clear_cmd(); err_clr = 0;
    check("err_beats_clr", err_timing, 1);
    pulse_clr();
    set_cmd(1, 1, 1, 17'd0);
    tick(); clear_cmd();
    check("proto_err", err_proto, 1);
    check("proto_not_fwd", dfi_cs_n, 1);
    repeat (10) tick();
    bus.valid = 0; bus.last = 1;
    tick(); bus.last = 0;
    pulse_clr();
    repeat (2) tick();

    // Reset in the middle of a grant.
    wait_grant(lat);
    set_cmd(1, 1, 0, 17'd0);
    tick();
    sys_rst_n = 0; bus.valid = 0; bus.last = 0;
    tick();
    clear_cmd();
    check("mid_rst_ready",  bus.ready,  0);
    check("mid_rst_block",  bm_block,   0);
    check("mid_rst_cs_n",   dfi_cs_n,   1);
    check("mid_rst_issued", ref_issued, 0);
    sys_rst_n = 1;
    tick();

    // ref_issued wrap: back-to-back REFs in one long grant.
    trfc_cfg = 8'd1; postpone_cfg = 4'd15;
    wait_grant(lat);
    set_cmd(1, 1, 0, 17'd0);
    repeat (65535) tick();
    check("issued_ffff", ref_issued, 16'hFFFF);
    tick();
    check("issued_wrap", ref_issued, 0);
    clear_cmd();
    bus.valid = 0; bus.last = 1;
    tick(); bus.last = 0;
    check("sat_count_ok", err_count, 0);
    check("wrap_no_timing", err_timing, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
